// File: rtl/tap_sum_engine.sv
// Accumulates the sum of a 15-entry sample register file, one new sample per pass.
// Addresses come from an external counter that is advanced by the Start and ReadEn strobes.
module tap_sum_engine #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              Start,
  output logic              ReadEn,
  input  logic [3:0]        WriteReg,
  input  logic [3:0]        ReadReg1,
  input  logic [3:0]        ReadReg2,
  input  logic [3:0]        ReadReg3,
  output logic              out_valid,
  output logic [DATA_W+3:0] out_data,
  input  logic              out_ready
);

  localparam int SUM_W    = DATA_W + 4;
  localparam int NUM_REGS = 15;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t                   state_q, state_d;
  logic [2:0]               beat_q, beat_d;
  logic [DATA_W-1:0]        hold_q, hold_d;
  logic signed [SUM_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]        regs_q [NUM_REGS];
  logic [DATA_W-1:0]        regs_d [NUM_REGS];
  logic [3:0]               rd_addr [3];
  logic signed [SUM_W-1:0]  beat_sum;

  assign rd_addr[0] = ReadReg1;
  assign rd_addr[1] = ReadReg2;
  assign rd_addr[2] = ReadReg3;

  // Address 15 is the counter's "no entry" code, so that read port contributes zero.
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < 3; i++) begin
      if (rd_addr[i] != 4'd15) begin
        beat_sum = beat_sum + SUM_W'($signed(regs_q[rd_addr[i]]));
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    hold_d    = hold_q;
    acc_d     = acc_q;
    regs_d    = regs_q;
    in_ready  = 1'b0;
    Start     = 1'b0;
    ReadEn    = 1'b0;
    out_valid = 1'b0;
    out_data  = acc_q;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          hold_d  = in_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        Start = 1'b1;
        if (WriteReg != 4'd15) begin
          regs_d[WriteReg] = hold_q;
        end
        beat_d  = '0;
        state_d = READ;
      end
      READ: begin
        ReadEn = 1'b1;
        acc_d  = ((beat_q == 3'd0) ? '0 : acc_q) + beat_sum;
        if (beat_q == 3'd4) begin
          beat_d  = '0;
          state_d = DONE;
        end else begin
          beat_d = beat_q + 3'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      hold_q  <= '0;
      acc_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      hold_q  <= hold_d;
      acc_q   <= acc_d;
      regs_q  <= regs_d;
    end
  end

endmodule

// File: tb/tb_tap_sum_engine.sv
// Bench for tap_sum_engine: models the external address counter and predicts each sum
// from a plain array of the stored samples.
module tb_tap_sum_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        Start;
  logic        ReadEn;
  logic [3:0]  WriteReg;
  logic [3:0]  ReadReg1;
  logic [3:0]  ReadReg2;
  logic [3:0]  ReadReg3;
  logic        out_valid;
  logic [19:0] out_data;
  logic        out_ready;

  int testsRun  = 0;
  int failCount = 0;

  logic [3:0] wrPtr;
  logic [2:0] rdBeat;
  bit         forceRd2 = 1'b0;
  bit         forceWr15 = 1'b0;

  int modelMem [15];
  int modelWr;

  tap_sum_engine #(.DATA_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .Start     (Start),
    .ReadEn    (ReadEn),
    .WriteReg  (WriteReg),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .ReadReg3  (ReadReg3),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // External address counter: write pointer wraps over 0..14, each read beat covers three entries.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr  <= 4'd0;
      rdBeat <= 3'd0;
    end else begin
      if (Start)  wrPtr  <= (wrPtr == 4'd14) ? 4'd0 : wrPtr + 4'd1;
      if (ReadEn) rdBeat <= (rdBeat == 3'd4) ? 3'd0 : rdBeat + 3'd1;
    end
  end

  always_comb begin
    WriteReg = forceWr15 ? 4'd15 : wrPtr;
    ReadReg1 = 4'(rdBeat * 3);
    ReadReg2 = forceRd2 ? 4'd15 : 4'(rdBeat * 3 + 1);
    ReadReg3 = 4'(rdBeat * 3 + 2);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [19:0] modelSum();
    int s = 0;
    for (int i = 0; i < 15; i++) begin
      if (!(forceRd2 && (i % 3 == 1))) s += modelMem[i];
    end
    return 20'(s);
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 15; i++) modelMem[i] = 0;
    modelWr = 0;
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    clearModel();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_start",    {31'b0, Start},     32'd0);
    checkOutput("rst_readen",   {31'b0, ReadEn},    32'd0);
    checkOutput("rst_outvalid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_outdata",  {12'b0, out_data},  32'd0);
    checkOutput("rst_inready",  {31'b0, in_ready},  32'd1);
  endtask

  // Push one sample, follow it to the result, optionally stalling the downstream side.
  task automatic applyStimulus(input logic [15:0] sample, input int holdCycles,
                               input bit checkLatency, input string tag);
    logic [19:0] expected;
    logic [19:0] firstData;
    int waitCnt = 0;
    while (!in_ready && waitCnt < 30) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!in_ready) begin
      checkOutput({tag, "_ready_timeout"}, 32'd0, 32'd1);
      return;
    end
    out_ready = (holdCycles == 0);
    in_valid  = 1'b1;
    in_data   = sample;
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (!forceWr15) modelMem[modelWr] = int'($signed(sample));
    modelWr  = (modelWr + 1) % 15;
    expected = modelSum();

    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (checkLatency && c <= 7) begin
        checkOutput($sformatf("%s_start_c%0d", tag, c),  {31'b0, Start},     {31'b0, c == 1});
        checkOutput($sformatf("%s_readen_c%0d", tag, c), {31'b0, ReadEn},    {31'b0, c >= 2 && c <= 6});
        checkOutput($sformatf("%s_valid_c%0d", tag, c),  {31'b0, out_valid}, {31'b0, c == 7});
        if (c == 1) checkOutput({tag, "_inready_busy"}, {31'b0, in_ready}, 32'd0);
      end
      if (out_valid) break;
    end
    if (!out_valid) begin
      checkOutput({tag, "_valid_timeout"}, 32'd0, 32'd1);
      return;
    end
    checkOutput({tag, "_data"}, {12'b0, out_data}, {12'b0, expected});
    firstData = out_data;

    for (int k = 1; k < holdCycles; k++) begin
      @(negedge clk);
      checkOutput({tag, "_hold_valid"},   {31'b0, out_valid}, 32'd1);
      checkOutput({tag, "_hold_data"},    {12'b0, out_data},  {12'b0, firstData});
      checkOutput({tag, "_hold_inready"}, {31'b0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_after_valid"},   {31'b0, out_valid}, 32'd0);
    checkOutput({tag, "_after_inready"}, {31'b0, in_ready},  32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] s;
    int hold;

    doReset();
    applyStimulus(16'd5, 0, 1'b1, "push5");

    doReset();
    for (int i = 1; i <= 15; i++) applyStimulus(16'(i), 0, 1'b0, $sformatf("seq%0d", i));
    checkOutput("seq_total_120", {12'b0, out_data}, 32'd120);
    applyStimulus(16'd100, 0, 1'b0, "evict");
    checkOutput("evict_219", {12'b0, out_data}, 32'd219);

    doReset();
    applyStimulus(16'hFFFD, 0, 1'b0, "neg3");
    checkOutput("neg3_fffffd", {12'b0, out_data}, 32'h000FFFFD);

    applyStimulus(16'd9, 4, 1'b0, "stall");

    // Abort during the third read beat: the pass must never produce a result.
    doReset();
    applyStimulus(16'd11, 0, 1'b0, "preabort");
    in_valid = 1'b1;
    in_data  = 16'd42;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    clearModel();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("abort_no_valid", {31'b0, out_valid}, 32'd0);
    end
    applyStimulus(16'd7, 0, 1'b0, "post_abort");
    checkOutput("post_abort_7", {12'b0, out_data}, 32'd7);

    doReset();
    for (int i = 0; i < 15; i++) applyStimulus(16'd1, 0, 1'b0, "ones");
    forceRd2 = 1'b1;
    applyStimulus(16'd1, 0, 1'b0, "rd15");
    checkOutput("rd15_sum10", {12'b0, out_data}, 32'd10);
    forceRd2  = 1'b0;
    forceWr15 = 1'b1;
    applyStimulus(16'd50, 0, 1'b0, "wr15");
    checkOutput("wr15_sum15", {12'b0, out_data}, 32'd15);
    forceWr15 = 1'b0;

    doReset();
    for (int n = 0; n < 30; n++) begin
      s         = 16'($urandom);
      hold      = $urandom_range(0, 3);
      forceRd2  = ($urandom_range(0, 5) == 0);
      forceWr15 = ($urandom_range(0, 7) == 0);
      applyStimulus(s, hold, 1'b0, $sformatf("rand%0d", n));
      forceRd2  = 1'b0;
      forceWr15 = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
